// File: rtl/matrix_row_mem_sequencer.sv
// -----------------------------------------------------------------------------
// matrix_row_mem_sequencer
//
// Turns one matrix load/store command (base, stride, row count) into a series
// of full-width row transactions on the mem_* request interface. Only one
// transaction is ever outstanding. Load rows are streamed out on the ld_*
// valid/ready port. Store rows are taken from the st_* valid/ready port.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   cmd_*                command handshake: we (1=store), base, stride, nrows
//   ld_data_o/valid/last load row output; ld_ready_i is the consumer ready
//   st_data_i/valid      store row input; st_ready_o accepts the row
//   mem_req/we/be/addr/wdata, mem_gnt_i, mem_rvalid_i, mem_rdata_i
//                        request/response side towards the memory bridge
//   busy_o               sequencer is not idle
//   done_o               one-cycle pulse on the first idle cycle after a command
// -----------------------------------------------------------------------------
module matrix_row_mem_sequencer #(
    parameter int BUS_WIDTH = 128,
    parameter int MAX_ROWS  = 16,
    parameter int CNT_W     = $clog2(MAX_ROWS + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_we_i,
    input  logic [31:0]            cmd_base_i,
    input  logic [31:0]            cmd_stride_i,
    input  logic [CNT_W-1:0]       cmd_nrows_i,
    output logic [BUS_WIDTH-1:0]   ld_data_o,
    output logic                   ld_valid_o,
    input  logic                   ld_ready_i,
    output logic                   ld_last_o,
    input  logic [BUS_WIDTH-1:0]   st_data_i,
    input  logic                   st_valid_i,
    output logic                   st_ready_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [BUS_WIDTH/8-1:0] mem_be_o,
    output logic [31:0]            mem_addr_o,
    output logic [BUS_WIDTH-1:0]   mem_wdata_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [BUS_WIDTH-1:0]   mem_rdata_i,
    output logic                   busy_o,
    output logic                   done_o
);

    generate
        if (BUS_WIDTH != 128) begin : g_bad_width
            $error("matrix_row_mem_sequencer: BUS_WIDTH must be 128");
        end
    endgenerate

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] REQ      = 3'd2;
    localparam logic [2:0] RESP     = 3'd3;
    localparam logic [2:0] LD_OUT   = 3'd4;

    logic [2:0]           state_q;
    logic                 we_q;
    logic [31:0]          addr_q;
    logic [31:0]          stride_q;
    logic [CNT_W-1:0]     nrows_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BUS_WIDTH-1:0] wdata_q;
    logic [BUS_WIDTH-1:0] rdata_q;
    logic                 done_q;

    logic [CNT_W-1:0]     cnt_inc;
    logic                 advance;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // A row is finished either when a store response arrives or when the
    // consumer takes a load row.
    assign advance = ((state_q == RESP) && mem_rvalid_i && we_q) ||
                     ((state_q == LD_OUT) && ld_ready_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            stride_q <= '0;
            nrows_q  <= '0;
            cnt_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        we_q     <= cmd_we_i;
                        addr_q   <= cmd_base_i;
                        stride_q <= cmd_stride_i;
                        nrows_q  <= cmd_nrows_i;
                        cnt_q    <= '0;
                        if (cmd_nrows_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= cmd_we_i ? ST_FETCH : REQ;
                        end
                    end
                end
                ST_FETCH: begin
                    if (st_valid_i) begin
                        wdata_q <= st_data_i;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    // Store responses are handled by the row advance below.
                    if (mem_rvalid_i && !we_q) begin
                        rdata_q <= mem_rdata_i;
                        state_q <= LD_OUT;
                    end
                end
                LD_OUT: begin
                end
                default: state_q <= IDLE;
            endcase

            if (advance) begin
                cnt_q  <= cnt_inc;
                addr_q <= addr_q + stride_q;
                if (cnt_inc == nrows_q) begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= we_q ? ST_FETCH : REQ;
                end
            end
        end
    end

    // Outputs decode straight from the state register so that an asynchronous
    // reset drops the request and load-valid immediately.
    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign st_ready_o  = (state_q == ST_FETCH);
    assign mem_req_o   = (state_q == REQ);
    assign mem_we_o    = (state_q == REQ) && we_q;
    assign mem_be_o    = '1;
    assign mem_addr_o  = {addr_q[31:4], 4'b0000};
    assign mem_wdata_o = wdata_q;
    assign ld_valid_o  = (state_q == LD_OUT);
    assign ld_data_o   = rdata_q;
    assign ld_last_o   = (state_q == LD_OUT) && (cnt_q == nrows_q - CNT_W'(1));

endmodule

// File: tb/tb_matrix_row_mem_sequencer.sv
// -----------------------------------------------------------------------------
// tb_matrix_row_mem_sequencer
//
// Directed bench for matrix_row_mem_sequencer. The bench plays the role of the
// command source, the load consumer, the store producer and the memory bridge.
// -----------------------------------------------------------------------------
module tb_matrix_row_mem_sequencer;

    localparam int BW    = 128;
    localparam int CNT_W = 5;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic             cmd_we_i;
    logic [31:0]      cmd_base_i;
    logic [31:0]      cmd_stride_i;
    logic [CNT_W-1:0] cmd_nrows_i;
    logic [BW-1:0]    ld_data_o;
    logic             ld_valid_o;
    logic             ld_ready_i;
    logic             ld_last_o;
    logic [BW-1:0]    st_data_i;
    logic             st_valid_i;
    logic             st_ready_o;
    logic             mem_req_o;
    logic             mem_we_o;
    logic [BW/8-1:0]  mem_be_o;
    logic [31:0]      mem_addr_o;
    logic [BW-1:0]    mem_wdata_o;
    logic             mem_gnt_i;
    logic             mem_rvalid_i;
    logic [BW-1:0]    mem_rdata_i;
    logic             busy_o;
    logic             done_o;

    int checks = 0;
    int errors = 0;

    matrix_row_mem_sequencer #(.BUS_WIDTH(128), .MAX_ROWS(16)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_we_i     (cmd_we_i),
        .cmd_base_i   (cmd_base_i),
        .cmd_stride_i (cmd_stride_i),
        .cmd_nrows_i  (cmd_nrows_i),
        .ld_data_o    (ld_data_o),
        .ld_valid_o   (ld_valid_o),
        .ld_ready_i   (ld_ready_i),
        .ld_last_o    (ld_last_o),
        .st_data_i    (st_data_i),
        .st_valid_i   (st_valid_i),
        .st_ready_o   (st_ready_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] ld_pat(input int row);
        return {4{32'hA5A5_0000 + 32'(row)}};
    endfunction

    function automatic logic [BW-1:0] st_pat(input int row);
        return {4{32'h5A5A_1000 + 32'(row)}};
    endfunction

    initial begin
        rst_ni       = 1'b0;
        cmd_valid_i  = 1'b0;
        cmd_we_i     = 1'b0;
        cmd_base_i   = '0;
        cmd_stride_i = '0;
        cmd_nrows_i  = '0;
        ld_ready_i   = 1'b0;
        st_data_i    = '0;
        st_valid_i   = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;

        // ---------------- reset state ----------------
        #2;
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_busy",      busy_o, 0);
        chk("rst_done",      done_o, 0);
        chk("rst_mem_req",   mem_req_o, 0);
        chk("rst_mem_we",    mem_we_o, 0);
        chk("rst_mem_be",    mem_be_o, 16'hFFFF);
        chk("rst_mem_addr",  mem_addr_o, 0);
        chk("rst_wdata",     mem_wdata_o, 0);
        chk("rst_ld_valid",  ld_valid_o, 0);
        chk("rst_ld_last",   ld_last_o, 0);
        chk("rst_ld_data",   ld_data_o, 0);
        chk("rst_st_ready",  st_ready_o, 0);
        step();
        step();
        rst_ni = 1'b1;
        step();

        // ---------------- load, 4 rows, 3 cycles/row ----------------
        mem_gnt_i    = 1'b1;
        ld_ready_i   = 1'b1;
        cmd_valid_i  = 1'b1;
        cmd_we_i     = 1'b0;
        cmd_base_i   = 32'h0000_1000;
        cmd_stride_i = 32'h0000_0040;
        cmd_nrows_i  = 5'd4;
        step();
        cmd_valid_i = 1'b0;
        for (int r = 0; r < 4; r++) begin
            chk("ld_req",       mem_req_o, 1);
            chk("ld_addr",      mem_addr_o, 32'h1000 + 32'(r) * 32'h40);
            chk("ld_we",        mem_we_o, 0);
            chk("ld_be",        mem_be_o, 16'hFFFF);
            chk("ld_busy",      busy_o, 1);
            chk("ld_cmd_ready", cmd_ready_o, 0);
            step();
            chk("ld_resp_req",  mem_req_o, 0);
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = ld_pat(r);
            step();
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
            chk("ld_valid", ld_valid_o, 1);
            chk("ld_data",  ld_data_o, ld_pat(r));
            chk("ld_last",  ld_last_o, (r == 3) ? 1 : 0);
            chk("ld_done_early", done_o, 0);
            step();
        end
        chk("ld_done",       done_o, 1);
        chk("ld_done_ready", cmd_ready_o, 1);
        chk("ld_done_busy",  busy_o, 0);
        step();
        chk("ld_done_once",  done_o, 0);

        // ---------------- store, 2 rows, stalls on st_valid and gnt ----------------
        mem_gnt_i    = 1'b0;
        cmd_valid_i  = 1'b1;
        cmd_we_i     = 1'b1;
        cmd_base_i   = 32'h0000_2000;
        cmd_stride_i = 32'h0000_0100;
        cmd_nrows_i  = 5'd2;
        step();
        cmd_valid_i = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int w = 0; w < 5; w++) begin
                chk("st_fetch_ready", st_ready_o, 1);
                chk("st_fetch_req",   mem_req_o, 0);
                step();
            end
            st_valid_i = 1'b1;
            st_data_i  = st_pat(r);
            step();
            st_valid_i = 1'b0;
            st_data_i  = {BW{1'b1}};
            for (int g = 0; g < 4; g++) begin
                chk("st_req",      mem_req_o, 1);
                chk("st_we",       mem_we_o, 1);
                chk("st_addr",     mem_addr_o, 32'h2000 + 32'(r) * 32'h100);
                chk("st_wdata",    mem_wdata_o, st_pat(r));
                chk("st_ready_req", st_ready_o, 0);
                if (g == 3) mem_gnt_i = 1'b1;
                step();
            end
            mem_gnt_i = 1'b0;
            chk("st_resp_req",   mem_req_o, 0);
            chk("st_resp_ready", st_ready_o, 0);
            mem_rvalid_i = 1'b1;
            step();
            mem_rvalid_i = 1'b0;
            chk("st_done", done_o, (r == 1) ? 1 : 0);
        end
        chk("st_done_busy", busy_o, 0);
        step();

        // ---------------- load with 10-cycle consumer stall ----------------
        mem_gnt_i    = 1'b1;
        ld_ready_i   = 1'b0;
        cmd_valid_i  = 1'b1;
        cmd_we_i     = 1'b0;
        cmd_base_i   = 32'h0000_3000;
        cmd_stride_i = 32'h0000_0020;
        cmd_nrows_i  = 5'd2;
        step();
        cmd_valid_i = 1'b0;
        chk("bp_addr0", mem_addr_o, 32'h3000);
        step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = ld_pat(7);
        step();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = ld_pat(99);
        for (int s = 0; s < 10; s++) begin
            chk("bp_valid", ld_valid_o, 1);
            chk("bp_data",  ld_data_o, ld_pat(7));
            chk("bp_last",  ld_last_o, 0);
            chk("bp_noreq", mem_req_o, 0);
            step();
        end
        ld_ready_i = 1'b1;
        step();
        chk("bp_req1",  mem_req_o, 1);
        chk("bp_addr1", mem_addr_o, 32'h3020);
        step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = ld_pat(8);
        step();
        mem_rvalid_i = 1'b0;
        chk("bp_data1", ld_data_o, ld_pat(8));
        chk("bp_last1", ld_last_o, 1);
        step();
        chk("bp_done", done_o, 1);
        step();

        // ---------------- zero-row command ----------------
        cmd_valid_i = 1'b1;
        cmd_nrows_i = 5'd0;
        chk("z_ready", cmd_ready_o, 1);
        step();
        cmd_valid_i = 1'b0;
        chk("z_done",  done_o, 1);
        chk("z_busy",  busy_o, 0);
        chk("z_req",   mem_req_o, 0);
        step();
        chk("z_done_once", done_o, 0);
        chk("z_busy2",     busy_o, 0);
        chk("z_req2",      mem_req_o, 0);

        // ---------------- address wrap ----------------
        cmd_valid_i  = 1'b1;
        cmd_base_i   = 32'hFFFF_FFF0;
        cmd_stride_i = 32'h0000_0010;
        cmd_nrows_i  = 5'd2;
        step();
        cmd_valid_i = 1'b0;
        for (int r = 0; r < 2; r++) begin
            chk("wrap_addr", mem_addr_o, (r == 0) ? 32'hFFFF_FFF0 : 32'h0000_0000);
            step();
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = ld_pat(20 + r);
            step();
            mem_rvalid_i = 1'b0;
            chk("wrap_data", ld_data_o, ld_pat(20 + r));
            step();
        end
        chk("wrap_done", done_o, 1);
        step();

        // ---------------- asynchronous reset while in RESP ----------------
        cmd_valid_i  = 1'b1;
        cmd_base_i   = 32'h0000_5000;
        cmd_stride_i = 32'h0000_0010;
        cmd_nrows_i  = 5'd3;
        mem_gnt_i    = 1'b1;
        step();
        cmd_valid_i = 1'b0;
        chk("ar_req_before", mem_req_o, 1);
        step();
        chk("ar_in_resp", busy_o, 1);
        rst_ni       = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = ld_pat(55);
        #1;
        chk("ar_req",       mem_req_o, 0);
        chk("ar_ld_valid",  ld_valid_o, 0);
        chk("ar_cmd_ready", cmd_ready_o, 1);
        chk("ar_busy",      busy_o, 0);
        step();
        rst_ni       = 1'b1;
        mem_rvalid_i = 1'b0;
        step();
        chk("ar_idle_valid", ld_valid_o, 0);
        cmd_valid_i  = 1'b1;
        cmd_base_i   = 32'h0000_6000;
        cmd_stride_i = 32'h0000_0040;
        cmd_nrows_i  = 5'd1;
        step();
        cmd_valid_i = 1'b0;
        chk("ar_new_req",  mem_req_o, 1);
        chk("ar_new_addr", mem_addr_o, 32'h6000);
        step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = ld_pat(60);
        step();
        mem_rvalid_i = 1'b0;
        chk("ar_new_data", ld_data_o, ld_pat(60));
        chk("ar_new_last", ld_last_o, 1);
        step();
        chk("ar_new_done", done_o, 1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
